// File: rtl/ibex_pkg.sv
// Shared ALU types for the ALU request sequencer: operator encoding, sequencer
// states, the intermediate-value register count and the multi-cycle operator test.
package ibex_pkg;

    typedef enum logic [6:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_XOR,
        ALU_OR,
        ALU_AND,
        ALU_SRA,
        ALU_SRL,
        ALU_SLL,
        ALU_ROR,
        ALU_ROL,
        ALU_LT,
        ALU_LTU,
        ALU_GE,
        ALU_GEU,
        ALU_EQ,
        ALU_NE,
        ALU_SLT,
        ALU_SLTU,
        ALU_CMOV,
        ALU_CMIX,
        ALU_FSL,
        ALU_FSR
    } alu_op_e;

    typedef enum logic [2:0] {
        AluSeqIdle,
        AluSeqExec1,
        AluSeqExec2,
        AluSeqResp,
        AluSeqMd
    } ibex_alu_seq_state_e;

    localparam int unsigned AluImdNum = 2;

    // Operators that need a second ALU cycle and the intermediate-value registers.
    function automatic logic alu_op_multicycle(alu_op_e op);
        logic w_multi;
        case (op)
            ALU_ROR, ALU_ROL, ALU_CMOV, ALU_CMIX, ALU_FSL, ALU_FSR: w_multi = 1'b1;
            default:                                                w_multi = 1'b0;
        endcase
        return w_multi;
    endfunction

endpackage

// File: rtl/ibex_alu_seq_imd_regs.sv
// Intermediate-value registers written by the ALU during multi-cycle operations.
module ibex_alu_seq_imd_regs
    import ibex_pkg::*;
(
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           en_i,
    input  logic [AluImdNum-1:0]           we_i,
    input  logic [AluImdNum-1:0][31:0]     d_i,
    output logic [AluImdNum-1:0][31:0]     q_o
);

    for (genvar g = 0; g < AluImdNum; g++) begin : g_imd
        logic [31:0] r_q;

        // Each entry loads only while an ALU operation is executing.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_q <= '0;
            end else if (en_i && we_i[g]) begin
                r_q <= d_i[g];
            end
        end

        assign q_o[g] = r_q;
    end

endmodule

// File: rtl/ibex_alu_seq.sv
// ALU request sequencer: accepts one ALU request at a time, drives the shared ALU,
// registers the response and lends the ALU adder to the multiplier/divider when idle.
// Build option: IBEX_ALU_SEQ_MULTICYCLE_EN enables the second execute cycle and the
// intermediate-value registers; without it multi-cycle operators return an error.
module ibex_alu_seq
    import ibex_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  alu_op_e                    req_op_i,
    input  logic [31:0]                req_a_i,
    input  logic [31:0]                req_b_i,
    output logic                       resp_valid_o,
    input  logic                       resp_ready_i,
    output logic [31:0]                resp_result_o,
    output logic                       resp_cmp_o,
    output logic                       resp_err_o,
    output alu_op_e                    alu_operator_o,
    output logic [31:0]                alu_operand_a_o,
    output logic [31:0]                alu_operand_b_o,
    output logic                       alu_instr_first_cycle_o,
    output logic [AluImdNum-1:0][31:0] alu_imd_val_q_o,
    input  logic [AluImdNum-1:0]       alu_imd_val_we_i,
    input  logic [AluImdNum-1:0][31:0] alu_imd_val_d_i,
    input  logic [31:0]                alu_result_i,
    input  logic                       alu_cmp_i,
    input  logic                       md_req_i,
    output logic                       md_gnt_o,
    output logic                       alu_multdiv_sel_o
);

    ibex_alu_seq_state_e r_state, w_state_d;
    alu_op_e             r_op;
    logic [31:0]         r_a, r_b, r_result;
    logic                r_cmp, r_err, r_fair;
    logic                w_md_take, w_md_hold, w_md_exit, w_accept;
    logic                w_multi, w_capture, w_err, w_exec;

    // Multdiv wins an idle-cycle tie unless it was the last one served.
    assign w_md_take   = (r_state == AluSeqIdle) && md_req_i && !(r_fair && req_valid_i);
    assign w_md_hold   = (r_state == AluSeqMd) && md_req_i;
    assign w_md_exit   = (r_state == AluSeqMd) && !md_req_i;
    assign req_ready_o = (r_state == AluSeqIdle) && !w_md_take && !rst_i;
    assign w_accept    = req_valid_i && req_ready_o;
    assign w_multi     = alu_op_multicycle(r_op);
    assign w_exec      = (r_state == AluSeqExec1) || (r_state == AluSeqExec2);

`ifdef IBEX_ALU_SEQ_MULTICYCLE_EN
    assign w_err = 1'b0;
`else
    assign w_err = w_multi;
`endif

    // Result is taken on the last execute cycle, whichever that is.
    assign w_capture = ((r_state == AluSeqExec1) && (w_state_d == AluSeqResp)) ||
                       (r_state == AluSeqExec2);

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= AluSeqIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            AluSeqIdle: begin
                if (w_md_take) begin
                    w_state_d = AluSeqMd;
                end else if (w_accept) begin
                    w_state_d = AluSeqExec1;
                end
            end
            AluSeqExec1: begin
`ifdef IBEX_ALU_SEQ_MULTICYCLE_EN
                w_state_d = w_multi ? AluSeqExec2 : AluSeqResp;
`else
                w_state_d = AluSeqResp;
`endif
            end
`ifdef IBEX_ALU_SEQ_MULTICYCLE_EN
            AluSeqExec2: w_state_d = AluSeqResp;
`endif
            AluSeqResp:  if (resp_ready_i) w_state_d = AluSeqIdle;
            AluSeqMd:    if (!md_req_i) w_state_d = AluSeqIdle;
            default:     w_state_d = AluSeqIdle;
        endcase
    end

    // ALU and multdiv-grant outputs; the ALU sees ADD with zero operands when unused.
    always_comb begin
        alu_operator_o          = ALU_ADD;
        alu_operand_a_o         = '0;
        alu_operand_b_o         = '0;
        alu_instr_first_cycle_o = 1'b0;
        md_gnt_o                = w_md_take || w_md_hold;
        alu_multdiv_sel_o       = w_md_take || w_md_hold;
        if (w_exec) begin
            alu_operator_o          = r_op;
            alu_operand_a_o         = r_a;
            alu_operand_b_o         = r_b;
            alu_instr_first_cycle_o = (r_state == AluSeqExec1);
        end
    end

    // Request latch, response capture and fairness flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_op     <= ALU_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_cmp    <= 1'b0;
            r_err    <= 1'b0;
            r_fair   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op <= req_op_i;
                r_a  <= req_a_i;
                r_b  <= req_b_i;
            end
            if (w_capture) begin
                r_result <= w_err ? 32'h0 : alu_result_i;
                r_cmp    <= w_err ? 1'b0 : alu_cmp_i;
                r_err    <= w_err;
            end
            if (w_md_exit) begin
                r_fair <= 1'b1;
            end else if (w_accept) begin
                r_fair <= 1'b0;
            end
        end
    end

    assign resp_valid_o  = (r_state == AluSeqResp);
    assign resp_result_o = r_result;
    assign resp_cmp_o    = r_cmp;
    assign resp_err_o    = r_err;

`ifdef IBEX_ALU_SEQ_MULTICYCLE_EN
    ibex_alu_seq_imd_regs u_imd_regs (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (w_exec),
        .we_i  (alu_imd_val_we_i),
        .d_i   (alu_imd_val_d_i),
        .q_o   (alu_imd_val_q_o)
    );
`else
    logic w_unused_imd;
    assign w_unused_imd    = ^{alu_imd_val_we_i, alu_imd_val_d_i};
    assign alu_imd_val_q_o = '0;
`endif

endmodule

// File: tb/tb_ibex_alu_seq.sv
// Directed bench for ibex_alu_seq with a small behavioural ALU stub.
module tb_ibex_alu_seq;
    import ibex_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       req_valid = 1'b0, req_ready;
    alu_op_e                    req_op = ALU_ADD;
    logic [31:0]                req_a = '0, req_b = '0;
    logic                       resp_valid, resp_ready = 1'b1;
    logic [31:0]                resp_result;
    logic                       resp_cmp, resp_err;
    alu_op_e                    alu_op;
    logic [31:0]                alu_a, alu_b;
    logic                       first_cycle;
    logic [AluImdNum-1:0][31:0] imd_q;
    logic [AluImdNum-1:0]       imd_we;
    logic [AluImdNum-1:0][31:0] imd_d;
    logic [31:0]                alu_res;
    logic                       alu_cmp;
    logic                       md_req = 1'b0, md_gnt, md_sel;

    int checks = 0;
    int failures = 0;

    ibex_alu_seq dut (
        .clk_i                   (clk),
        .rst_i                   (rst),
        .req_valid_i             (req_valid),
        .req_ready_o             (req_ready),
        .req_op_i                (req_op),
        .req_a_i                 (req_a),
        .req_b_i                 (req_b),
        .resp_valid_o            (resp_valid),
        .resp_ready_i            (resp_ready),
        .resp_result_o           (resp_result),
        .resp_cmp_o              (resp_cmp),
        .resp_err_o              (resp_err),
        .alu_operator_o          (alu_op),
        .alu_operand_a_o         (alu_a),
        .alu_operand_b_o         (alu_b),
        .alu_instr_first_cycle_o (first_cycle),
        .alu_imd_val_q_o         (imd_q),
        .alu_imd_val_we_i        (imd_we),
        .alu_imd_val_d_i         (imd_d),
        .alu_result_i            (alu_res),
        .alu_cmp_i               (alu_cmp),
        .md_req_i                (md_req),
        .md_gnt_o                (md_gnt),
        .alu_multdiv_sel_o       (md_sel)
    );

    always #5 clk = ~clk;

    // ALU stub; it asserts write-enables all the time so the sequencer must gate them.
    always_comb begin
        logic [63:0] rot;
        alu_res = '0;
        alu_cmp = 1'b0;
        rot     = {alu_a, alu_a} >> alu_b[4:0];
        case (alu_op)
            ALU_ADD: alu_res = alu_a + alu_b;
            ALU_SUB: alu_res = alu_a - alu_b;
            ALU_XOR: alu_res = alu_a ^ alu_b;
            ALU_OR:  alu_res = alu_a | alu_b;
            ALU_AND: alu_res = alu_a & alu_b;
            ALU_EQ:  begin alu_cmp = (alu_a == alu_b); alu_res = {31'b0, alu_cmp}; end
            ALU_LTU: begin alu_cmp = (alu_a < alu_b); alu_res = {31'b0, alu_cmp}; end
            ALU_SLT: begin
                alu_cmp = ($signed(alu_a) < $signed(alu_b));
                alu_res = {31'b0, alu_cmp};
            end
            ALU_ROR: alu_res = rot[31:0];
            default: alu_res = '0;
        endcase
        imd_we   = 2'b11;
        imd_d[0] = alu_a ^ 32'h5A5A_5A5A;
        imd_d[1] = alu_b + 32'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one request from IDLE and stop at the first cycle with resp_valid_o high.
    task automatic do_op(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat);
        int n;
        int lat;
        n = 0;
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            cyc();
            n++;
        end
        chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
        cyc();
        req_valid = 1'b0;
        chk("exec1_first_cycle", {31'b0, first_cycle}, 32'd1);
        chk("exec1_operator", 32'(alu_op), 32'(op));
        chk("exec1_operand_a", alu_a, a);
        chk("exec1_operand_b", alu_b, b);
        chk("exec1_ready_low", {31'b0, req_ready}, 32'd0);
        lat = 1;
        while (!resp_valid && lat < 10) begin
            cyc();
            lat++;
            if (lat == 2 && exp_lat == 3) chk("exec2_first_cycle", {31'b0, first_cycle}, 32'd0);
        end
        chk("resp_latency", 32'(lat), 32'(exp_lat));
    endtask

    typedef struct {
        alu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        cmp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int bad;
        vecs[0] = '{ALU_AND, 32'hFFFF_FF00, 32'h00FF_FFFF, 32'h00FF_FF00, 1'b0};
        vecs[1] = '{ALU_OR,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0};
        vecs[2] = '{ALU_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1'b0};
        vecs[3] = '{ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0};
        vecs[4] = '{ALU_SUB, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0};
        vecs[5] = '{ALU_EQ,  32'h0000_ABCD, 32'h0000_ABCD, 32'h0000_0001, 1'b1};
        vecs[6] = '{ALU_LTU, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
        vecs[7] = '{ALU_SLT, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b1};

        // Reset values, then ready in the first cycle after release.
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_gnt_sel", {30'b0, md_gnt, md_sel}, 32'd0);
        chk("rst_operator", 32'(alu_op), 32'(ALU_ADD));
        chk("rst_imd0", imd_q[0], 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
        cyc();
        chk("idle_imd_ignored", imd_q[0], 32'h0);
        chk("idle_operand_a", alu_a, 32'h0);

        // Single-cycle operators.
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, 2);
            chk($sformatf("vec%0d_result", i), resp_result, vecs[i].res);
            chk($sformatf("vec%0d_cmp", i), {31'b0, resp_cmp}, {31'b0, vecs[i].cmp});
            chk($sformatf("vec%0d_err", i), {31'b0, resp_err}, 32'd0);
            cyc();
            chk($sformatf("vec%0d_done", i), {31'b0, resp_valid}, 32'd0);
        end

        // Multi-cycle operator.
`ifdef IBEX_ALU_SEQ_MULTICYCLE_EN
        do_op(ALU_ROR, 32'h0000_00F1, 32'd4, 3);
        chk("ror_result", resp_result, 32'h1000_000F);
        chk("ror_err", {31'b0, resp_err}, 32'd0);
        chk("ror_imd0", imd_q[0], 32'h5A5A_5AAB);
        chk("ror_imd1", imd_q[1], 32'h0000_0005);
        cyc();
        chk("ror_imd0_held", imd_q[0], 32'h5A5A_5AAB);
`else
        do_op(ALU_ROR, 32'h0000_00F1, 32'd4, 2);
        chk("ror_result", resp_result, 32'h0);
        chk("ror_err", {31'b0, resp_err}, 32'd1);
        chk("ror_imd0", imd_q[0], 32'h0);
        cyc();
`endif

        // Back-pressure: response held, no accept on the handshake cycle.
        resp_ready = 1'b0;
        do_op(ALU_ADD, 32'h0000_0100, 32'h0000_0023, 2);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_valid", {31'b0, resp_valid}, 32'd1);
            chk("bp_result", resp_result, 32'h0000_0123);
            chk("bp_ready", {31'b0, req_ready}, 32'd0);
        end
        req_op = ALU_OR; req_a = 32'hF0; req_b = 32'h0F; req_valid = 1'b1;
        resp_ready = 1'b1;
        cyc();
        chk("bp_release_valid", {31'b0, resp_valid}, 32'd0);
        chk("bp_release_idle", {31'b0, req_ready}, 32'd1);
        cyc();
        req_valid = 1'b0;
        chk("bp_next_exec1", {31'b0, first_cycle}, 32'd1);
        cyc();
        chk("bp_next_result", resp_result, 32'h0000_00FF);
        cyc();

        // Tie in IDLE: multdiv first, then the waiting ALU request beats it.
        md_req = 1'b1;
        req_op = ALU_ADD; req_a = 32'd1; req_b = 32'd1; req_valid = 1'b1;
        #1;
        chk("tie_gnt", {31'b0, md_gnt}, 32'd1);
        chk("tie_sel", {31'b0, md_sel}, 32'd1);
        chk("tie_ready", {31'b0, req_ready}, 32'd0);
        cyc();
        chk("md_gnt_held", {31'b0, md_gnt}, 32'd1);
        chk("md_operand_a", alu_a, 32'h0);
        cyc();
        md_req = 1'b0;
        #1;
        chk("md_drop_gnt", {31'b0, md_gnt}, 32'd0);
        cyc();
        md_req = 1'b1;
        #1;
        chk("fair_gnt", {31'b0, md_gnt}, 32'd0);
        chk("fair_ready", {31'b0, req_ready}, 32'd1);
        cyc();
        req_valid = 1'b0;
        chk("fair_exec1", {31'b0, first_cycle}, 32'd1);
        chk("fair_exec1_gnt", {31'b0, md_gnt}, 32'd0);
        cyc();
        chk("fair_resp_result", resp_result, 32'd2);
        chk("fair_resp_gnt", {31'b0, md_gnt}, 32'd0);
        cyc();
        chk("fair_cleared_gnt", {31'b0, md_gnt}, 32'd1);
        md_req = 1'b0;
        cyc();

        // Multdiv request raised mid-operation is held off until IDLE.
        resp_ready = 1'b0;
        req_op = ALU_SUB; req_a = 32'd9; req_b = 32'd4; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        md_req = 1'b1;
        #1;
        chk("mid_exec1_gnt", {31'b0, md_gnt}, 32'd0);
        cyc();
        chk("mid_resp_gnt", {31'b0, md_gnt}, 32'd0);
        chk("mid_resp_result", resp_result, 32'd5);
        cyc();
        chk("mid_resp2_gnt", {31'b0, md_gnt}, 32'd0);
        resp_ready = 1'b1;
        cyc();
        chk("mid_idle_gnt", {31'b0, md_gnt}, 32'd1);
        md_req = 1'b0;
        cyc();
        cyc();

        // Reset during the multi-cycle operation abandons it.
        req_op = ALU_ROR; req_a = 32'h1; req_b = 32'h1; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
`ifdef IBEX_ALU_SEQ_MULTICYCLE_EN
        cyc();
        chk("abort_in_exec2", {31'b0, first_cycle}, 32'd0);
`endif
        rst = 1'b1;
        #1;
        chk("abort_ready", {31'b0, req_ready}, 32'd0);
        chk("abort_valid", {31'b0, resp_valid}, 32'd0);
        chk("abort_operator", 32'(alu_op), 32'(ALU_ADD));
        chk("abort_operand_a", alu_a, 32'h0);
        chk("abort_first", {31'b0, first_cycle}, 32'd0);
        chk("abort_imd", imd_q[0] | imd_q[1], 32'h0);
        chk("abort_resp_regs", resp_result | {30'b0, resp_cmp, resp_err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_post_ready", {31'b0, req_ready}, 32'd1);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (resp_valid) bad++;
        end
        chk("abort_no_resp", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ibex_alu_seq.md
IBEX_ALU_SEQ -- requirements
Module: ibex_alu_seq

Interface
REQ-001 SHALL: clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_i  input  1  asynchronous, active-high reset.
REQ-003 SHALL: req_valid_i in 1 / req_ready_o out 1  request handshake; req_op_i in ibex_pkg::alu_op_e; req_a_i, req_b_i in 32 each, operands.
REQ-004 SHALL: resp_valid_o out 1 / resp_ready_i in 1  response handshake; resp_result_o out 32; resp_cmp_o out 1; resp_err_o out 1.
REQ-005 SHALL: alu_operator_o out alu_op_e; alu_operand_a_o, alu_operand_b_o out 32; alu_instr_first_cycle_o out 1; alu_imd_val_q_o out 2x32, to ALU.
REQ-006 SHALL: alu_imd_val_we_i in 2; alu_imd_val_d_i in 2x32; alu_result_i in 32; alu_cmp_i in 1, from ALU.
REQ-007 SHALL: md_req_i in 1 / md_gnt_o out 1  multdiv adder-sharing request/grant; alu_multdiv_sel_o out 1.

Function
REQ-008 SHALL: FSM states IDLE, EXEC1, EXEC2, RESP, MD.
REQ-009 SHALL: req_ready_o=1 only in IDLE with no multdiv grant taken that cycle; accept on req_valid_i&req_ready_o latches op, a, b.
REQ-010 SHALL: IDLE->EXEC1 on accept; EXEC1 drives latched op/operands with alu_instr_first_cycle_o=1.
REQ-011 SHALL: single-cycle op: EXEC1->RESP, result/cmp registered; accept cycle N -> resp_valid_o=1 at N+2.
REQ-012 SHALL: multi-cycle op (ibex_pkg::alu_op_multicycle true): EXEC1->EXEC2, first_cycle=0 in EXEC2; EXEC2->RESP; resp_valid_o at N+3.
REQ-013 SHALL: RESP holds resp_* stable until resp_ready_i; RESP->IDLE on resp_ready_i; no new accept in the same cycle.
REQ-014 SHALL: imd_val_q[i] <= alu_imd_val_d_i[i] when alu_imd_val_we_i[i] is set in EXEC1/EXEC2; ignored in other states.
REQ-015 SHALL: IDLE with md_req_i=1 -> MD, md_gnt_o=1, alu_multdiv_sel_o=1, held while md_req_i=1; MD->IDLE on md_req_i=0.
REQ-016 SHALL: simultaneous md_req_i and req_valid_i in IDLE: multdiv wins unless fairness flag set; flag set on MD exit, cleared on next ALU accept.
REQ-017 SHALL: md_req_i during EXEC1/EXEC2/RESP never preempts; md_gnt_o stays 0 until IDLE.
REQ-018 SHALL: alu_multdiv_sel_o=0 and alu_operator_o=ALU_ADD, operands 0 outside EXEC*/MD.

Reset
REQ-019 SHALL: reset forces IDLE; req_ready_o=0 during reset, 1 in the first cycle after; resp_valid_o, resp_result_o, resp_cmp_o, resp_err_o, md_gnt_o, alu_multdiv_sel_o, imd_val_q, fairness flag = 0.
REQ-020 SHALL: reset mid-operation abandons the op; no response produced.

Configuration
REQ-021 SHALL: IBEX_ALU_SEQ_MULTICYCLE_EN defined: REQ-012/014 behaviour, imd registers present.
REQ-022 SHALL: macro undefined: EXEC2 and imd registers removed, alu_imd_val_q_o=0; multi-cycle op goes EXEC1->RESP with resp_err_o=1, resp_result_o=0.

Structure
REQ-023 SHALL: ibex_pkg gains ibex_alu_seq_state_e and function alu_op_multicycle(alu_op_e).
REQ-024 SHALL: imd registers in sub-module ibex_alu_seq_imd_regs (generate-loop over 2 entries).

Verification
REQ-025 SHALL: ALU_AND, a=32'hFFFFFF00, b=32'h00FFFFFF, resp_ready_i=1 -> resp_result_o=32'h00FFFF00 two cycles after accept.
REQ-026 SHALL: multi-cycle op with macro -> first_cycle 1 then 0, imd_val_q updated, resp_valid_o at N+3; without macro -> resp_err_o=1 at N+2.
REQ-027 SHALL: md_req_i and req_valid_i both high in IDLE -> md_gnt_o=1 first; after md_req_i drops, pending ALU accepted before a reasserted md_req_i.
REQ-028 SHALL: md_req_i raised in EXEC1 -> md_gnt_o=0 until response handshake done.
REQ-029 SHALL: resp_ready_i=0 for 5 cycles -> resp_* stable, req_ready_o=0 throughout.
REQ-030 SHALL: rst_i pulsed in EXEC2 -> all outputs at reset values, no resp_valid_o afterwards.
